// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared OFDM receiver defaults and the symbol sequencer state type
package ofdm_pkg;
  localparam int N_FFT_DEF  = 64;
  localparam int CP_LEN_DEF = 16;
  localparam int DW_DEF     = 12;
  typedef enum logic [1:0] {IDLE, SKIP_CP, FWD} sym_state_e;
endpackage

// File: rtl/fft_sym_sequencer.sv
// fft_sym_sequencer: strips the cyclic prefix and frames N_FFT-sample symbols for an FFT core
//   clk, reset_n                         clock, async active-low reset
//   in_valid/in_real/in_imag/sym_start   time-domain samples, sym_start marks first CP sample
//   fft_sink_ready                       FFT core ready; a stall drops the symbol
//   fft_sink_valid/sop/eop/real/imag     registered FFT input stream (1 clk latency)
//   fft_sink_error/fftpts/inverse        constant FFT configuration
//   sym_cnt                              symbols whose eop the FFT accepted
//   ovf_sticky/sync_err_sticky/clr_sticky error flags and their clear
module fft_sym_sequencer
  import ofdm_pkg::*;
#(
  parameter int N_FFT  = N_FFT_DEF,
  parameter int CP_LEN = CP_LEN_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  input  logic          sym_start,
  input  logic          fft_sink_ready,
  output logic          fft_sink_valid,
  output logic          fft_sink_sop,
  output logic          fft_sink_eop,
  output logic [DW-1:0] fft_sink_real,
  output logic [DW-1:0] fft_sink_imag,
  output logic [1:0]    fft_sink_error,
  output logic [7:0]    fftpts,
  output logic          inverse,
  output logic [15:0]   sym_cnt,
  output logic          ovf_sticky,
  output logic          sync_err_sticky,
  input  logic          clr_sticky
);
  localparam int CW = $clog2(N_FFT);
  sym_state_e state_q, state_d, cur;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_evt, start, fwd, last;
  assign fft_sink_error = 2'b00;
  assign fftpts = 8'(N_FFT);
  assign inverse = 1'b0;
  // A stalled output abandons the symbol; the current input is then judged as if idle,
  // so a sym_start arriving in the stall cycle still opens a new symbol.
  assign ovf_evt = fft_sink_valid && !fft_sink_ready;
  assign cur = ovf_evt ? IDLE : state_q;
  assign start = in_valid && sym_start;
  assign last = cnt_q == CW'(N_FFT - 1);
  assign fwd = in_valid && (cur == FWD || (cur == IDLE && sym_start && CP_LEN == 0));
  assign state_d = cur == IDLE ? (start ? (CP_LEN > 1 ? SKIP_CP : FWD) : IDLE)
                 : !in_valid ? cur
                 : cur == SKIP_CP ? (cnt_q == CW'(CP_LEN - 1) ? FWD : SKIP_CP)
                 : (last ? IDLE : FWD);
  // With no CP the start sample itself is forwarded, so counting resumes at 1.
  assign cnt_d = cur == IDLE ? (start && CP_LEN != 1 ? CW'(1) : '0)
               : !in_valid ? cnt_q
               : state_d != cur ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sym_cnt <= '0;
      fft_sink_valid <= 1'b0;
      fft_sink_sop <= 1'b0;
      fft_sink_eop <= 1'b0;
      fft_sink_real <= '0;
      fft_sink_imag <= '0;
      ovf_sticky <= 1'b0;
      sync_err_sticky <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fft_sink_valid <= fwd;
      fft_sink_sop <= fwd && (cur == IDLE || cnt_q == '0);
      fft_sink_eop <= fwd && cur == FWD && last;
      if (fwd) begin
        fft_sink_real <= in_real;
        fft_sink_imag <= in_imag;
      end
      if (fft_sink_valid && fft_sink_ready && fft_sink_eop) sym_cnt <= sym_cnt + 16'd1;
      ovf_sticky <= ovf_evt || (ovf_sticky && !clr_sticky);
      sync_err_sticky <= (start && cur != IDLE) || (sync_err_sticky && !clr_sticky);
    end
  end
endmodule

// File: doc/fft_sym_sequencer.md
FFT_SYM_SEQUENCER -- requirements
Module: fft_sym_sequencer

Interface
REQ-001 The block SHALL have parameter N_FFT, default 64, meaning the FFT length in samples (power of two, 8..128).
REQ-002 The block SHALL have parameter CP_LEN, default 16, meaning the cyclic-prefix samples discarded per symbol (0..N_FFT-1).
REQ-003 The block SHALL have parameter DW, default 12, meaning the sample width per I/Q component.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning a time-domain sample is present; there is no backpressure.
REQ-007 The block SHALL have ports in_real and in_imag, input, DW bits each, meaning signed sample I/Q.
REQ-008 The block SHALL have port sym_start, input, 1 bit, meaning the current valid sample is the first sample of a symbol, CP included.
REQ-009 The block SHALL have port fft_sink_ready, input, 1 bit, meaning the FFT core accepts input.
REQ-010 The block SHALL have ports fft_sink_valid, fft_sink_sop and fft_sink_eop, output, 1 bit each, meaning the FFT input framing.
REQ-011 The block SHALL have ports fft_sink_real and fft_sink_imag, output, DW bits each, meaning the forwarded samples.
REQ-012 The block SHALL have port fft_sink_error, output, 2 bits, meaning the FFT error input.
REQ-013 The block SHALL have ports fftpts and inverse, output, 8 and 1 bits, meaning the FFT configuration.
REQ-014 The block SHALL have port sym_cnt, output, 16 bits, meaning the number of completed symbols handed to the FFT.
REQ-015 The block SHALL have ports ovf_sticky and sync_err_sticky, output, 1 bit each, meaning the error flags.
REQ-016 The block SHALL have port clr_sticky, input, 1 bit, meaning a synchronous clear of both sticky flags.

Function
REQ-017 The FSM SHALL have states IDLE, SKIP_CP and FWD, with a sample counter cnt of width clog2(N_FFT).
REQ-018 In IDLE, in_valid&&sym_start SHALL enter SKIP_CP with cnt=1 when CP_LEN>1, enter FWD with cnt=0 when CP_LEN=1, and forward the sample as sop when CP_LEN=0.
REQ-019 In SKIP_CP, each valid sample SHALL increment cnt and be discarded; the CP_LEN-th sample SHALL move the FSM to FWD with cnt=0.
REQ-020 In FWD, each valid sample SHALL be registered to the fft_sink_* outputs with fft_sink_valid=1 for exactly one cycle, so latency is 1 clk.
REQ-021 fft_sink_sop SHALL be 1 on the first forwarded sample (cnt=0) and fft_sink_eop SHALL be 1 on cnt=N_FFT-1; after eop the FSM SHALL return to IDLE and sym_cnt SHALL increment, wrapping 0xFFFF->0.
REQ-022 Handshake: any cycle with fft_sink_valid=1 and fft_sink_ready=0 SHALL set ovf_sticky, drop the symbol and force the FSM to IDLE without emitting eop; that symbol SHALL NOT be counted.
REQ-023 sym_start asserted in SKIP_CP or FWD SHALL be ignored, the symbol in progress SHALL continue, and sync_err_sticky SHALL be set.
REQ-024 A sym_start on the same cycle as an eop forward SHALL be treated as IDLE-entry, with no gap and no sync error.
REQ-025 in_valid=0 cycles SHALL hold cnt and state, and SHALL drive fft_sink_valid, fft_sink_sop and fft_sink_eop to 0.
REQ-026 fft_sink_error SHALL be constant 2'b00, fftpts SHALL be constant N_FFT[7:0], and inverse SHALL be constant 0.
REQ-027 clr_sticky SHALL clear both sticky flags, and a set event in the same cycle SHALL win.

Reset
REQ-028 Reset SHALL be asynchronous on reset_n low and SHALL give state=IDLE, cnt=0, sym_cnt=0, fft_sink_valid/sop/eop=0, fft_sink_real/imag=0, and both sticky flags=0.
REQ-029 Reset mid-symbol SHALL abandon the symbol; the first symbol after release SHALL begin with sop only on a new sym_start.

Structure
REQ-030 A shared package ofdm_pkg SHALL hold the N_FFT, CP_LEN and DW defaults and the FSM state type.
REQ-031 The design SHALL be single-level with no sub-module, wired to the FFT core instance by the enclosing receiver top.

Verification
REQ-032 With ready=1, two back-to-back 80-sample symbols SHALL give 2x64 forwarded samples, sop on sample 16 and eop on sample 79 of each, and sym_cnt=2.
REQ-033 With ready dropped at forwarded sample 30, ovf_sticky SHALL be 1, no eop SHALL be emitted, sym_cnt SHALL be unchanged, and the next symbol SHALL be forwarded correctly.
REQ-034 A sym_start at sample 40 of a symbol SHALL set sync_err_sticky, and the original symbol's eop SHALL still occur at sample 79.
REQ-035 With in_valid toggling 1/0 every cycle, sop, eop and the count SHALL still be correct, and fft_sink_valid SHALL never be 1 on an idle cycle.
REQ-036 Asserting reset_n low at forwarded sample 20 SHALL take all outputs to their reset values asynchronously, and after release with no sym_start there SHALL be no output.
REQ-037 With CP_LEN=0, a sym_start sample SHALL be forwarded immediately with sop=1.
